// File: rtl/axi_wr_arb2.sv
// ---------------------------------------------------------------------------
// axi_wr_arb2
//
// Shares one AXI3 master write channel between two on-chip requesters. Each
// requester offers a single-beat write (address, data, strobes) with a
// valid/ready handshake. The granted write is issued as an AXI single
// transfer (awlen = 0). The block then waits for the B response and returns
// the response code to the requester that issued the write, together with a
// one-cycle done pulse.
//
// Ports
//   aclk_i, arstn_i          clock, synchronous active-low reset
//   reqN_valid_i/addr/data/strb   requester N write request
//   reqN_ready_o             request accepted this cycle (IDLE only)
//   reqN_done_o/resp_o       completion pulse and held response code
//   busy_o                   a transaction is in flight
//   aw*/w*/b*                AXI3 write address, data and response channels
// ---------------------------------------------------------------------------
module axi_wr_arb2 #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int IW = 4
) (
    input  logic              aclk_i,
    input  logic              arstn_i,
    input  logic              req0_valid_i,
    input  logic [AW-1:0]     req0_addr_i,
    input  logic [DW-1:0]     req0_data_i,
    input  logic [DW/8-1:0]   req0_strb_i,
    output logic              req0_ready_o,
    output logic              req0_done_o,
    output logic [1:0]        req0_resp_o,
    input  logic              req1_valid_i,
    input  logic [AW-1:0]     req1_addr_i,
    input  logic [DW-1:0]     req1_data_i,
    input  logic [DW/8-1:0]   req1_strb_i,
    output logic              req1_ready_o,
    output logic              req1_done_o,
    output logic [1:0]        req1_resp_o,
    output logic              busy_o,
    output logic [IW-1:0]     awid_o,
    output logic [AW-1:0]     awaddr_o,
    output logic [3:0]        awlen_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DW-1:0]     wdata_o,
    output logic [DW/8-1:0]   wstrb_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [IW-1:0]     bid_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    localparam int SW = DW / 8;
    localparam logic [2:0] AWSIZE = 3'($clog2(SW));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   strb_q, strb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic [1:0]      resp0_q, resp0_d;
    logic [1:0]      resp1_q, resp1_d;

    logic            grant_any;
    logic            grant_idx;
    logic            aw_left;
    logic            w_left;
    logic [1:0]      resp_sel;
    logic            bid_unused;

    // Only bit 0 of the returned ID carries the requester index.
    assign bid_unused = ^bid_i;

    // Grant is offered only in IDLE and never while reset is held low, so a
    // requester cannot see ready during a reset cycle. When both requesters
    // are pending the one that did not win last time gets the channel.
    always_comb begin
        grant_any = (req0_valid_i | req1_valid_i) & arstn_i & (state_q == IDLE);
        if (req0_valid_i && req1_valid_i) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req1_valid_i;
        end
    end

    assign req0_ready_o = grant_any & ~grant_idx;
    assign req1_ready_o = grant_any & grant_idx;

    // Next-state logic. AW and W each retire independently; the B phase
    // starts only once neither channel still has an outstanding beat.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        resp0_d      = resp0_q;
        resp1_d      = resp1_q;
        aw_left      = awvalid_q & ~awready_i;
        w_left       = wvalid_q & ~wready_i;
        resp_sel     = (bid_i[0] != idx_q) ? 2'b10 : bresp_i;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    idx_d        = grant_idx;
                    last_grant_d = grant_idx;
                    addr_d       = grant_idx ? req1_addr_i : req0_addr_i;
                    data_d       = grant_idx ? req1_data_i : req0_data_i;
                    strb_d       = grant_idx ? req1_strb_i : req0_strb_i;
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                    state_d      = XFER;
                end
            end
            XFER: begin
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bvalid_i) begin
                    if (idx_q) begin
                        done1_d = 1'b1;
                        resp1_d = resp_sel;
                    end else begin
                        done0_d = 1'b1;
                        resp0_d = resp_sel;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. last_grant resets to 1 so requester 0 wins the first
    // contended arbitration after reset.
    always_ff @(posedge aclk_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            idx_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            strb_q       <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            resp0_q      <= 2'b00;
            resp1_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
        end
    end

    always_comb begin
        awid_o    = '0;
        awid_o[0] = idx_q;
    end

    assign awaddr_o    = addr_q;
    assign awlen_o     = 4'd0;
    assign awsize_o    = AWSIZE;
    assign awburst_o   = 2'b01;
    assign awvalid_o   = awvalid_q;
    assign wdata_o     = data_q;
    assign wstrb_o     = strb_q;
    assign wlast_o     = wvalid_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign req0_done_o = done0_q;
    assign req1_done_o = done1_q;
    assign req0_resp_o = resp0_q;
    assign req1_resp_o = resp1_q;

endmodule

// File: tb/tb_axi_wr_arb2.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arb2
//
// Directed bench for axi_wr_arb2. Requesters and a configurable AXI slave are
// driven on the falling clock edge. Expected AW, W and B results are queued
// when a request is granted; a monitor pops and compares them whenever the
// DUT completes a handshake or a done pulse.
// ---------------------------------------------------------------------------
module tb_axi_wr_arb2;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            arstn;
    logic            req0_valid, req1_valid;
    logic [AW-1:0]   req0_addr, req1_addr;
    logic [DW-1:0]   req0_data, req1_data;
    logic [SW-1:0]   req0_strb, req1_strb;
    logic            req0_ready_o, req1_ready_o;
    logic            req0_done_o, req1_done_o;
    logic [1:0]      req0_resp_o, req1_resp_o;
    logic            busy_o;
    logic [IW-1:0]   awid_o;
    logic [AW-1:0]   awaddr_o;
    logic [3:0]      awlen_o;
    logic [2:0]      awsize_o;
    logic [1:0]      awburst_o;
    logic            awvalid_o, awready;
    logic [DW-1:0]   wdata_o;
    logic [SW-1:0]   wstrb_o;
    logic            wlast_o, wvalid_o, wready;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bvalid, bready_o;

    int vectors = 0;
    int miscompares = 0;

    // Slave behaviour knobs
    int            aw_delay = 0;
    int            w_delay = 0;
    int            b_delay = 0;
    logic [1:0]    cfg_bresp = 2'b00;
    logic          bid_force_en = 1'b0;
    logic [IW-1:0] bid_force_val = '0;

    typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; } aw_exp_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } w_exp_t;
    typedef struct { logic idx; logic [1:0] resp; } b_exp_t;

    aw_exp_t awq[$];
    w_exp_t  wq[$];
    b_exp_t  bq[$];
    logic    glog[$];

    always #5 clk = ~clk;

    axi_wr_arb2 #(.AW(AW), .DW(DW), .IW(IW)) dut (
        .aclk_i(clk),            .arstn_i(arstn),
        .req0_valid_i(req0_valid), .req0_addr_i(req0_addr),
        .req0_data_i(req0_data), .req0_strb_i(req0_strb),
        .req0_ready_o(req0_ready_o), .req0_done_o(req0_done_o),
        .req0_resp_o(req0_resp_o),
        .req1_valid_i(req1_valid), .req1_addr_i(req1_addr),
        .req1_data_i(req1_data), .req1_strb_i(req1_strb),
        .req1_ready_o(req1_ready_o), .req1_done_o(req1_done_o),
        .req1_resp_o(req1_resp_o),
        .busy_o(busy_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awvalid_o(awvalid_o), .awready_i(awready),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready_o)
    );

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flagFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endfunction

    // Issue one request from requester idx, starting just after a falling
    // edge. Expectations are queued on the cycle the request is granted.
    task automatic applyStimulus(input logic idx, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                 input logic [1:0] exp_resp, output int wait_cycles);
        aw_exp_t a;
        w_exp_t  w;
        b_exp_t  b;
        logic    granted;
        granted = 1'b0;
        wait_cycles = 0;
        if (idx) begin
            req1_valid = 1'b1; req1_addr = addr; req1_data = data; req1_strb = strb;
        end else begin
            req0_valid = 1'b1; req0_addr = addr; req0_data = data; req0_strb = strb;
        end
        for (int c = 0; c < 200; c++) begin
            #2;
            if ((idx && req1_ready_o) || (!idx && req0_ready_o)) begin
                a.id = '0; a.id[0] = idx; a.addr = addr;
                w.data = data; w.strb = strb;
                b.idx = idx; b.resp = exp_resp;
                awq.push_back(a); wq.push_back(w); bq.push_back(b);
                glog.push_back(idx);
                wait_cycles = c;
                granted = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!granted) begin
            vectors++; miscompares++;
            $display("[TB] FAIL grant timeout req%0d: got no ready, expected ready", idx);
        end
        if (idx) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic waitIdle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #2;
            if (!busy_o && bq.size() == 0 && !req0_ready_o && !req1_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL idle timeout: got busy=%0d pending=%0d, expected idle", busy_o, bq.size());
        end
        @(negedge clk);
    endtask

    // AXI slave: each ready rises after its programmed number of wait
    // cycles; B is returned once bready is seen and the B delay has elapsed.
    initial begin
        int aw_cnt, w_cnt, b_cnt;
        logic [IW-1:0] id_rec;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; id_rec = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (awvalid_o === 1'b1 && !awready) begin
                if (aw_cnt >= aw_delay) begin
                    awready = 1'b1;
                    id_rec  = awid_o;
                end else begin
                    aw_cnt++;
                end
            end else begin
                awready = 1'b0;
                aw_cnt  = 0;
            end
            if (wvalid_o === 1'b1 && !wready) begin
                if (w_cnt >= w_delay) wready = 1'b1;
                else w_cnt++;
            end else begin
                wready = 1'b0;
                w_cnt  = 0;
            end
            if (bvalid) begin
                bvalid = 1'b0;
            end else if (bready_o === 1'b1) begin
                if (b_cnt >= b_delay) begin
                    bvalid = 1'b1;
                    bid    = bid_force_en ? bid_force_val : id_rec;
                    bresp  = cfg_bresp;
                    b_cnt  = 0;
                end else begin
                    b_cnt++;
                end
            end else begin
                b_cnt = 0;
            end
        end
    end

    // Monitor: compares each handshake and completion against the queues.
    initial begin
        aw_exp_t a;
        w_exp_t  w;
        b_exp_t  b;
        forever begin
            @(negedge clk);
            #2;
            if (awvalid_o === 1'b1 && awready) begin
                if (awq.size() == 0) flagFail("unexpected AW");
                else begin
                    a = awq.pop_front();
                    checkOutput("awaddr", 64'(awaddr_o), 64'(a.addr));
                    checkOutput("awid", 64'(awid_o), 64'(a.id));
                    checkOutput("awlen", 64'(awlen_o), 64'd0);
                    checkOutput("awsize", 64'(awsize_o), 64'd3);
                    checkOutput("awburst", 64'(awburst_o), 64'd1);
                end
            end
            if (wvalid_o === 1'b1 && wready) begin
                if (wq.size() == 0) flagFail("unexpected W");
                else begin
                    w = wq.pop_front();
                    checkOutput("wdata", 64'(wdata_o), 64'(w.data));
                    checkOutput("wstrb", 64'(wstrb_o), 64'(w.strb));
                    checkOutput("wlast", 64'(wlast_o), 64'd1);
                end
            end
            if (req0_done_o === 1'b1 || req1_done_o === 1'b1) begin
                if (bq.size() == 0) flagFail("unexpected done");
                else begin
                    b = bq.pop_front();
                    checkOutput("done0", 64'(req0_done_o), 64'(!b.idx));
                    checkOutput("done1", 64'(req1_done_o), 64'(b.idx));
                    checkOutput("resp", 64'(b.idx ? req1_resp_o : req0_resp_o), 64'(b.resp));
                end
            end
            if (req0_ready_o === 1'b1 || req1_ready_o === 1'b1) begin
                checkOutput("ready only in idle", 64'(busy_o), 64'd0);
                checkOutput("single ready", 64'(req0_ready_o & req1_ready_o), 64'd0);
            end
        end
    end

    initial begin
        int wc;
        logic [63:0] order;
        arstn = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_addr = '0; req0_data = '0; req0_strb = '0;
        req1_addr = '0; req1_data = '0; req1_strb = '0;

        // Reset values, with a request held to show ready is gated by reset
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst ready0", 64'(req0_ready_o), 64'd0);
        checkOutput("rst awvalid", 64'(awvalid_o), 64'd0);
        checkOutput("rst wvalid", 64'(wvalid_o), 64'd0);
        checkOutput("rst bready", 64'(bready_o), 64'd0);
        checkOutput("rst busy", 64'(busy_o), 64'd0);
        checkOutput("rst awaddr", 64'(awaddr_o), 64'd0);
        checkOutput("rst wdata", 64'(wdata_o), 64'd0);
        checkOutput("rst awid", 64'(awid_o), 64'd0);
        checkOutput("rst resp", 64'({req0_resp_o, req1_resp_o}), 64'd0);
        checkOutput("rst done", 64'({req0_done_o, req1_done_o}), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        arstn = 1'b1;
        @(negedge clk);

        // Single zero-wait write from requester 0
        applyStimulus(1'b0, 32'h4000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, wc);
        checkOutput("single ready latency", 64'(wc), 64'd0);
        #2;
        checkOutput("T+1 awvalid", 64'(awvalid_o), 64'd1);
        checkOutput("T+1 wvalid", 64'(wvalid_o), 64'd1);
        checkOutput("T+1 busy", 64'(busy_o), 64'd1);
        @(negedge clk); #2;
        checkOutput("T+2 valids", 64'({awvalid_o, wvalid_o}), 64'd0);
        checkOutput("T+2 bready", 64'(bready_o), 64'd1);
        @(negedge clk); #2;
        checkOutput("T+3 done0", 64'(req0_done_o), 64'd1);
        checkOutput("T+3 busy", 64'(busy_o), 64'd0);
        waitIdle();

        // Error response on a requester 1 write
        cfg_bresp = 2'b11;
        applyStimulus(1'b1, 32'h0000_0200, 64'hDEAD_BEEF_0000_0001, 8'h0F, 2'b11, wc);
        waitIdle();
        cfg_bresp = 2'b00;
        checkOutput("resp1 held", 64'(req1_resp_o), 64'd3);

        // Contention: both requesters pending for four transactions
        glog.delete();
        fork
            begin
                applyStimulus(1'b0, 32'h0000_1000, 64'hA0A0_A0A0_0000_0000, 8'hFF, 2'b00, wc);
                applyStimulus(1'b0, 32'h0000_1008, 64'hA0A0_A0A0_0000_0002, 8'hF0, 2'b00, wc);
            end
            begin
                applyStimulus(1'b1, 32'h0000_2000, 64'hB1B1_B1B1_0000_0001, 8'h3C, 2'b00, wc);
                applyStimulus(1'b1, 32'h0000_2008, 64'hB1B1_B1B1_0000_0003, 8'hC3, 2'b00, wc);
            end
        join
        waitIdle();
        order = '0;
        checkOutput("grant count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) order[i] = glog[i];
        checkOutput("grant order", order, 64'b1010);

        // BID mismatch on a requester 1 write forces SLVERR
        bid_force_en = 1'b1; bid_force_val = '0;
        applyStimulus(1'b1, 32'h0000_3000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b10, wc);
        waitIdle();
        bid_force_en = 1'b0;

        // AW delayed, W immediate
        aw_delay = 3;
        applyStimulus(1'b0, 32'h0000_4000, 64'h0000_0000_CAFE_F00D, 8'h0F, 2'b00, wc);
        #2;
        checkOutput("skewA T+1 valids", 64'({awvalid_o, wvalid_o}), 64'b11);
        @(negedge clk); #2;
        checkOutput("skewA T+2 valids", 64'({awvalid_o, wvalid_o}), 64'b10);
        @(negedge clk); #2;
        @(negedge clk); #2;
        checkOutput("skewA T+4 aw/bready", 64'({awvalid_o, bready_o}), 64'b10);
        @(negedge clk); #2;
        checkOutput("skewA T+5 aw/bready", 64'({awvalid_o, bready_o}), 64'b01);
        waitIdle();

        // W delayed, AW immediate
        aw_delay = 0; w_delay = 3;
        applyStimulus(1'b1, 32'h0000_5000, 64'h5555_AAAA_5555_AAAA, 8'hAA, 2'b00, wc);
        #2;
        checkOutput("skewW T+1 valids", 64'({awvalid_o, wvalid_o}), 64'b11);
        @(negedge clk); #2;
        checkOutput("skewW T+2 valids", 64'({awvalid_o, wvalid_o}), 64'b01);
        @(negedge clk); #2;
        @(negedge clk); #2;
        checkOutput("skewW T+4 w/bready", 64'({wvalid_o, bready_o}), 64'b10);
        @(negedge clk); #2;
        checkOutput("skewW T+5 w/bready", 64'({wvalid_o, bready_o}), 64'b01);
        waitIdle();
        w_delay = 0;

        // Requester 1 raised while requester 0 waits in RESP
        b_delay = 3;
        fork
            applyStimulus(1'b0, 32'h0000_6000, 64'h6666_0000_6666_0000, 8'hFF, 2'b00, wc);
            begin
                int wc1;
                logic seen;
                seen = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk); #2;
                    if (bready_o) begin seen = 1'b1; break; end
                end
                checkOutput("held: reached RESP", 64'(seen), 64'd1);
                @(negedge clk);
                applyStimulus(1'b1, 32'h0000_7000, 64'h7777_1111_7777_1111, 8'h55, 2'b00, wc1);
                checkOutput("held: ready1 wait", 64'(wc1), 64'd3);
            end
        join
        waitIdle();
        b_delay = 0;

        // Reset during XFER with AW stalled
        aw_delay = 1000;
        applyStimulus(1'b0, 32'h0000_8000, 64'h8888_8888_8888_8888, 8'hFF, 2'b00, wc);
        @(negedge clk);
        arstn = 1'b0;
        awq.delete(); bq.delete();
        #2;
        checkOutput("pre-reset awvalid", 64'(awvalid_o), 64'd1);
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 32'h0000_9000; req0_data = 64'h9; req0_strb = 8'h01;
        req1_valid = 1'b1; req1_addr = 32'h0000_A000; req1_data = 64'hA; req1_strb = 8'h02;
        #2;
        checkOutput("reset awvalid/wvalid", 64'({awvalid_o, wvalid_o}), 64'd0);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset no done", 64'({req0_done_o, req1_done_o}), 64'd0);
        checkOutput("reset ready gated", 64'({req0_ready_o, req1_ready_o}), 64'd0);
        @(negedge clk);
        aw_delay = 0;
        arstn = 1'b1;
        #2;
        checkOutput("post-reset grant", 64'({req0_ready_o, req1_ready_o}), 64'b10);
        if (req0_ready_o) begin
            awq.push_back('{id: '0, addr: 32'h0000_9000});
            wq.push_back('{data: 64'h9, strb: 8'h01});
            bq.push_back('{idx: 1'b0, resp: 2'b00});
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        waitIdle();

        checkOutput("queues drained", 64'(awq.size() + wq.size() + bq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
